// File: rtl/data_mem_stage_pkg.sv
// Shared constants for the MEM-stage datapath: peripheral address map,
// timer control bit positions and the seven-segment glyph table.
package data_mem_stage_pkg;

    localparam logic [31:0] PERIPH_BASE = 32'h4000_0000;

    // Word offsets (Addr[4:2]) inside the peripheral window
    localparam logic [2:0] OFF_TH      = 3'd0;
    localparam logic [2:0] OFF_TL      = 3'd1;
    localparam logic [2:0] OFF_TCON    = 3'd2;
    localparam logic [2:0] OFF_LED     = 3'd3;
    localparam logic [2:0] OFF_DIGITS  = 3'd4;
    localparam logic [2:0] OFF_SYSTICK = 3'd5;

    localparam int TCON_EN  = 0;
    localparam int TCON_IE  = 1;
    localparam int TCON_OVF = 2;

    // Active-low {dp,g,f,e,d,c,b,a}; glyph n sits at bits [8n+7:8n]
    localparam logic [127:0] SEG_TABLE = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    function automatic logic [7:0] hex_to_seg(input logic [3:0] nibble);
        return SEG_TABLE[{nibble, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/data_mem_stage_if.sv
// EX/MEM-to-memory bus carrying the load/store request and the load word.
interface data_mem_stage_if;
    // No handshake: MemRead/MemWrite are qualifiers valid for the whole cycle,
    // the slave is always ready, and ReadData is valid in that same cycle.
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;

    modport master (output MemRead, output MemWrite, output Addr, output WriteData,
                    input ReadData);
    modport slave  (input MemRead, input MemWrite, input Addr, input WriteData,
                    output ReadData);
endinterface

// File: rtl/data_mem_stage_seg_scanner.sv
// Multiplexed 4-digit seven-segment driver: each digit is lit for SCAN_DIV
// cycles, An/Seg are registered and follow the DIGITS register.
module seg_scanner
    import data_mem_stage_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] digits,
    output logic [3:0]  an,
    output logic [7:0]  seg
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [1:0]    idx_next;
    logic          term;

    assign term     = (cnt == TERM);
    assign idx_next = term ? idx + 2'd1 : idx;

    // An/Seg are driven from the index the counter moves to, so they stay
    // aligned with idx and pick up a DIGITS change one cycle after it lands.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            idx <= 2'd0;
            an  <= 4'b1110;
            seg <= 8'hC0;
        end else begin
            cnt <= term ? '0 : cnt + 1'b1;
            idx <= idx_next;
            an  <= ~(4'b0001 << idx_next);
            seg <= hex_to_seg(digits[{idx_next, 2'b00} +: 4]);
        end
    end

endmodule

// File: rtl/data_mem_stage.sv
// MEM stage of the five-stage pipeline: data RAM with combinational read plus
// a memory-mapped timer, systick, LED register and display digit register.
module data_mem_stage
    import data_mem_stage_pkg::*;
#(
    parameter int RAM_WORDS = 512,
    parameter int SCAN_DIV  = 50000
) (
    input  logic              clk,
    input  logic              reset,
    data_mem_stage_if.slave   bus,
    output logic              Irq,
    output logic [7:0]        Leds,
    output logic [3:0]        An,
    output logic [7:0]        Seg
);

    localparam int AW = $clog2(RAM_WORDS);

    logic [31:0] ram [RAM_WORDS];
    logic [31:0] th, tl, systick;
    logic [2:0]  tcon;
    logic [7:0]  led_q;
    logic [15:0] digits;
    logic        irq_q;

    logic       ram_sel, periph_sel, wr, ovf;
    logic [2:0] off;
    logic       wr_th, wr_tl, wr_tcon, wr_led, wr_digits;

    assign ram_sel    = (bus.Addr[31:AW+2] == '0);
    assign periph_sel = (bus.Addr[31:5] == PERIPH_BASE[31:5]);
    assign off        = bus.Addr[4:2];
    assign wr         = bus.MemWrite & ~reset;

    assign wr_th     = wr & periph_sel & (off == OFF_TH);
    assign wr_tl     = wr & periph_sel & (off == OFF_TL);
    assign wr_tcon   = wr & periph_sel & (off == OFF_TCON);
    assign wr_led    = wr & periph_sel & (off == OFF_LED);
    assign wr_digits = wr & periph_sel & (off == OFF_DIGITS);

    assign ovf = tcon[TCON_EN] & (tl == 32'hFFFF_FFFF);

    always_ff @(posedge clk) begin
        if (wr && ram_sel) ram[bus.Addr[AW+1:2]] <= bus.WriteData;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            th      <= '0;
            tl      <= '0;
            tcon    <= '0;
            led_q   <= '0;
            digits  <= '0;
            systick <= '0;
            irq_q   <= 1'b0;
        end else begin
            systick <= systick + 32'd1;
            irq_q   <= tcon[TCON_IE] & tcon[TCON_OVF];
            if (wr_th) th <= bus.WriteData;
            if (wr_tl)               tl <= bus.WriteData;
            else if (tcon[TCON_EN])  tl <= ovf ? th : tl + 32'd1;
            // A same-cycle overflow is ORed into a CPU write so it is never lost
            if (wr_tcon)  tcon <= bus.WriteData[2:0] | {ovf, 2'b00};
            else if (ovf) tcon[TCON_OVF] <= 1'b1;
            if (wr_led)    led_q  <= bus.WriteData[7:0];
            if (wr_digits) digits <= bus.WriteData[15:0];
        end
    end

    always_comb begin
        bus.ReadData = '0;
        if (bus.MemRead) begin
            if (ram_sel) begin
                bus.ReadData = ram[bus.Addr[AW+1:2]];
            end else if (periph_sel) begin
                case (off)
                    OFF_TH:      bus.ReadData = th;
                    OFF_TL:      bus.ReadData = tl;
                    OFF_TCON:    bus.ReadData = {29'd0, tcon};
                    OFF_LED:     bus.ReadData = {24'd0, led_q};
                    OFF_DIGITS:  bus.ReadData = {16'd0, digits};
                    OFF_SYSTICK: bus.ReadData = systick;
                    default:     bus.ReadData = '0;
                endcase
            end
        end
    end

    assign Irq  = irq_q;
    assign Leds = led_q;

    seg_scanner #(.SCAN_DIV(SCAN_DIV)) u_seg_scanner (
        .clk    (clk),
        .reset  (reset),
        .digits (digits),
        .an     (An),
        .seg    (Seg)
    );

endmodule

// File: tb/tb_data_mem_stage.sv
// Directed bench for data_mem_stage: loads are scored through an expected
// queue by a negedge monitor; registered outputs are checked directly.
module tb_data_mem_stage;

    localparam logic [31:0] A_TH      = 32'h4000_0000;
    localparam logic [31:0] A_TL      = 32'h4000_0004;
    localparam logic [31:0] A_TCON    = 32'h4000_0008;
    localparam logic [31:0] A_LED     = 32'h4000_000C;
    localparam logic [31:0] A_DIGITS  = 32'h4000_0010;
    localparam logic [31:0] A_SYSTICK = 32'h4000_0014;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       irq;
    logic [7:0] leds;
    logic [3:0] an;
    logic [7:0] seg;

    int total = 0;
    int bad = 0;
    int cyc_count = 0;

    logic [31:0] exp_q[$];
    string       name_q[$];

    logic [3:0] an_exp  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [7:0] seg_exp [4] = '{8'h8E, 8'h88, 8'hA4, 8'hF9};

    data_mem_stage_if bus ();

    data_mem_stage #(.RAM_WORDS(512), .SCAN_DIV(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .Irq   (irq),
        .Leds  (leds),
        .An    (an),
        .Seg   (seg)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // driver tasks: inputs change at posedge+1 and are held for one cycle
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
        bus.MemRead   = rd;
        bus.MemWrite  = wr;
        bus.Addr      = a;
        bus.WriteData = d;
        @(posedge clk);
        #1;
        if (reset) cyc_count = 0;
        else       cyc_count++;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        cyc(1'b0, 1'b1, a, d);
    endtask

    task automatic load(input string name, input logic [31:0] a, input logic [31:0] e);
        exp_q.push_back(e);
        name_q.push_back(name);
        cyc(1'b1, 1'b0, a, 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    // scoreboard monitor: every cycle with MemRead set yields one load word
    always @(negedge clk) begin
        if (bus.MemRead === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_load: got %h expected no load", bus.ReadData);
            end else begin
                check(name_q.pop_front(), bus.ReadData, exp_q.pop_front());
            end
        end
    end

    initial begin
        bus.MemRead = 1'b0; bus.MemWrite = 1'b0; bus.Addr = '0; bus.WriteData = '0;
        @(posedge clk); #1;
        idle(2);
        reset = 1'b0;

        // reset state
        check("rst_leds", {24'd0, leds}, 32'h0);
        check("rst_an",   {28'd0, an},   32'hE);
        check("rst_seg",  {24'd0, seg},  32'hC0);
        check("rst_irq",  {31'd0, irq},  32'h0);
        load("rst_systick0", A_SYSTICK, cyc_count);
        load("rst_systick1", A_SYSTICK, cyc_count);
        load("rst_th",   A_TH,   32'h0);
        load("rst_tcon", A_TCON, 32'h0);

        // RAM store/load, ignored low bits, read-during-write
        store(32'h10, 32'hDEAD_BEEF);
        load("ram_ld",      32'h10, 32'hDEAD_BEEF);
        load("ram_ld_low3", 32'h13, 32'hDEAD_BEEF);
        exp_q.push_back(32'hDEAD_BEEF);
        name_q.push_back("ram_rdw_old");
        cyc(1'b1, 1'b1, 32'h10, 32'h1111_2222);
        store(32'h0, 32'h1234_5678);
        store(32'h800, 32'h77);
        load("ram_new",     32'h10,  32'h1111_2222);
        load("ram_noalias", 32'h0,   32'h1234_5678);
        load("ram_oob",     32'h800, 32'h0);

        // timer reload, overflow status and interrupt
        store(A_TH, 32'hFFFF_FFF0);
        store(A_TL, 32'hFFFF_FFFE);
        store(A_TCON, 32'h3);
        idle(2);
        load("tl_wrap", A_TL, 32'hFFFF_FFF0);
        check("irq_set", {31'd0, irq}, 32'h1);
        load("tcon_ovf", A_TCON, 32'h7);
        store(A_TCON, 32'h3);
        check("irq_lag", {31'd0, irq}, 32'h1);
        idle(1);
        check("irq_clr", {31'd0, irq}, 32'h0);

        // TCON write on the overflow cycle keeps the status bit
        store(A_TL, 32'hFFFF_FFFE);
        idle(1);
        store(A_TCON, 32'h3);
        load("tcon_collide", A_TCON, 32'h7);
        store(A_TL, 32'h100);
        load("tl_write_wins", A_TL, 32'h100);
        load("tl_incr",       A_TL, 32'h101);
        store(A_TCON, 32'h0);
        load("tcon_off", A_TCON, 32'h0);

        // LED register, narrow width
        store(A_LED, 32'h1A5);
        check("leds_out", {24'd0, leds}, 32'hA5);
        load("led_rd", A_LED, 32'hA5);

        // unmapped and read-only accesses
        load("unmapped_rd", 32'h4000_0020, 32'h0);
        store(32'h5000_0000, 32'hFFFF_FFFF);
        store(32'h4000_0018, 32'h55);
        store(A_SYSTICK, 32'h0);
        load("th_kept",  A_TH,  32'hFFFF_FFF0);
        load("led_kept", A_LED, 32'hA5);
        load("systick_ro", A_SYSTICK, cyc_count);
        cyc(1'b0, 1'b0, 32'h10, 32'h0);
        #1;
        check("noread_zero", bus.ReadData, 32'h0);

        // display scan with SCAN_DIV=2
        store(A_DIGITS, 32'h12AF);
        load("digits_rd", A_DIGITS, 32'h12AF);
        for (int i = 0; i < 10; i++) begin
            check("scan_an",  {28'd0, an},  {28'd0, an_exp[(cyc_count / 2) % 4]});
            check("scan_seg", {24'd0, seg}, {24'd0, seg_exp[(cyc_count / 2) % 4]});
            idle(1);
        end

        // reset while the timer runs and the display scans; write is dropped
        store(A_TH, 32'h0);
        store(A_TL, 32'hFFFF_FFFE);
        store(A_TCON, 32'h3);
        store(A_LED, 32'h3C);
        idle(2);
        check("pre_rst_irq", {31'd0, irq}, 32'h1);
        reset = 1'b1;
        cyc(1'b0, 1'b1, A_LED, 32'hFF);
        check("mid_rst_leds", {24'd0, leds}, 32'h0);
        check("mid_rst_an",   {28'd0, an},   32'hE);
        check("mid_rst_seg",  {24'd0, seg},  32'hC0);
        check("mid_rst_irq",  {31'd0, irq},  32'h0);
        reset = 1'b0;
        load("mid_rst_systick0", A_SYSTICK, cyc_count);
        load("mid_rst_systick1", A_SYSTICK, cyc_count);
        load("mid_rst_tl",     A_TL,     32'h0);
        load("mid_rst_th",     A_TH,     32'h0);
        load("mid_rst_tcon",   A_TCON,   32'h0);
        load("mid_rst_led",    A_LED,    32'h0);
        load("mid_rst_digits", A_DIGITS, 32'h0);
        idle(2);

        check("queue_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_mem_stage.md
# data_mem_stage

Memory-access stage datapath for the five-stage MIPS pipeline, between the EX/MEM and MEM/WB pipeline registers. Takes the registered address, store data and MemRead/MemWrite controls from EX/MEM. Returns the load word combinationally so MEM/WB captures it on the same edge. Contains the data RAM plus a memory-mapped peripheral window: a reloadable timer with interrupt, a free-running systick, LEDs and a scanned 4-digit seven-segment display.

## Interface
Parameters:
- RAM_WORDS, 512, data RAM depth in 32-bit words; power of two.
- SCAN_DIV, 50000, clk cycles each display digit is lit before advancing; ≥ 1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- MemRead  input  1  load in MEM stage (from EX/MEM).
- MemWrite  input  1  store in MEM stage (from EX/MEM).
- Addr  input  32  byte address (EX/MEM ALU result).
- WriteData  input  32  store data (EX/MEM rt data).
- ReadData  output  32  load data to MEM/WB, combinational.
- Irq  output  1  timer interrupt request, registered.
- Leds  output  8  LED register.
- An  output  4  digit enables, active-low one-hot.
- Seg  output  8  segments {dp,g,f,e,d,c,b,a}, active-low; dp always off.

## Operation
- Addr[1:0] ignored; word access only.
- Address map:
  - RAM at 0x0000_0000 .. 4*RAM_WORDS-1.
  - 0x4000_0000 TH (reload).
  - 0x4000_0004 TL (counter).
  - 0x4000_0008 TCON[2:0]:
    - bit0 enable.
    - bit1 irq enable.
    - bit2 overflow status.
  - 0x4000_000C LED[7:0].
  - 0x4000_0010 DIGITS[15:0]: four hex nibbles; nibble 0 = rightmost digit.
  - 0x4000_0014 SYSTICK (read-only).
- Read data:
  - ReadData = selected word when MemRead=1.
  - ReadData = 0 when MemRead=0 or the address is unmapped.
  - Unused upper bits of narrow registers read as 0.
- Writes:
  - A write occurs on the clock edge with MemWrite=1.
  - Unmapped and SYSTICK writes are ignored.
  - MemRead and MemWrite both set: read and write proceed independently, and the read returns the old value.
- Timer:
  - With TCON.bit0=1, TL increments every cycle.
  - When TL=0xFFFF_FFFF and enabled, next TL=TH and TCON.bit2 is set.
  - Irq = TCON.bit1 & TCON.bit2, registered (one-cycle lag).
- Timer write collisions:
  - A CPU write to TL wins over increment/reload.
  - A CPU write to TCON applies written bits, then an overflow in the same cycle ORs bit2 back in. Overflow is never lost.
- SYSTICK increments every cycle unconditionally and wraps at 2^32.
- Display: scan counter counts 0..SCAN_DIV-1. On terminal count it resets and digit index advances 0→1→2→3→0.
  - An = ~(1<<index).
  - Seg = hex-to-7seg of DIGITS nibble[index]; 0-F full hex set.
  - A DIGITS write takes effect in the current digit's next Seg value (one cycle).

## Timing
- Load latency: 0 cycles. ReadData is valid in the same cycle the EX/MEM outputs are valid.
- Store: visible to a load issued the next cycle.
- Reset values:
  - TH, TL, TCON, LED, DIGITS, SYSTICK, Irq = 0.
  - Scan counter = 0, index = 0, An = 4'b1110.
  - Seg = pattern for 0 (8'hC0).
  - RAM contents not reset.
- Reset mid-scan or mid-count: next cycle shows reset values. A write asserted during reset is dropped.
- All outputs except ReadData are registered.

## Structure
- Shared package contents:
  - address-map constants (base and offsets);
  - TCON bit indices;
  - hex-to-seven-segment constant table.
- Sub-module seg_scanner: scan counter, digit index, An/Seg registers.
  - Inputs: clk, reset, DIGITS.
  - Parameter: SCAN_DIV.
- RAM, timer, SYSTICK and address decode stay in data_mem_stage.

## Test plan
- Store 0xDEADBEEF to 0x0000_0010, load the same address next cycle → ReadData=0xDEADBEEF. Load 0x0000_0013 → same word (low bits ignored).
- TH=0xFFFF_FFF0, TL=0xFFFF_FFFE, TCON=3 → TL wraps to 0xFFFF_FFF0 after 2 cycles, TCON reads 7, Irq=1 one cycle later. Write TCON=3 → Irq drops.
- Write TCON=3 on the exact overflow cycle → TCON reads 7 afterwards (status retained).
- SCAN_DIV=2, DIGITS=0x12AF:
  - An sequence 1110,1101,1011,0111, each held 2 cycles, then wraps.
  - Seg sequence 8E,88,A4,F9.
- Load 0x4000_0020 and store 0x5000_0000 → ReadData=0 and no register changes. MemRead=0 → ReadData=0.
- Reset asserted while the timer runs and the display scans → all registers and outputs at their listed reset values the next cycle. SYSTICK=0, then increments by 1 per cycle.
